// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 8-bit accumulator CPU
//
// Contents:
//   fetch_state_t : instruction fetch sequencer states
//   ADDR_W/DATA_W : default address and data widths
//   OP_*          : opcode values carried in ira[7:4]
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    REQ_A = 3'd0,
    CAP_A = 3'd1,
    REQ_B = 3'd2,
    CAP_B = 3'd3,
    HOLD  = 3'd4
  } fetch_state_t;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_HALT   = 4'h7;
  localparam logic [3:0] OP_SKIP   = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;
  localparam logic [3:0] OP_CLEAR  = 4'hA;
  localparam logic [3:0] OP_RETURN = 4'hB;
  localparam logic [3:0] OP_JNS    = 4'hC;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - two-byte instruction fetch stage with PC and redirect
//
// Reads opcode byte (PC) then operand byte (PC+1) from a single-port
// synchronous RAM whenever the arbiter grants the bus, and presents the pair
// to execute over a valid/ready handshake.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus_gnt             : RAM port may be used this cycle
//   mem_addr/cs/oe      : RAM read request (combinational)
//   mem_rdata           : RAM data, one cycle after the request
//   ir_valid, ir_ready  : instruction handshake to execute
//   ira, irb            : opcode byte, operand byte (registered)
//   pc_next             : address after the held instruction (registered)
//   redirect_valid/pc   : load a new PC, aborting any fetch in progress
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_W,
  parameter int                    DATA_WIDTH = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ira,
  output logic [DATA_WIDTH-1:0] irb,
  output logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic                  ira_ld, irb_ld;

  assign pc_plus1 = pc_q + ONE;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_addr = pc_q;
    mem_cs   = 1'b0;
    ira_ld   = 1'b0;
    irb_ld   = 1'b0;

    case (state_q)
      REQ_A: begin
        if (bus_gnt) begin
          mem_cs  = 1'b1;
          state_d = CAP_A;
        end
      end
      CAP_A: begin
        ira_ld   = 1'b1;
        mem_addr = pc_plus1;
        // Issue the B read back-to-back if the bus is still ours.
        if (bus_gnt) begin
          mem_cs  = 1'b1;
          state_d = CAP_B;
        end else begin
          state_d = REQ_B;
        end
      end
      REQ_B: begin
        mem_addr = pc_plus1;
        if (bus_gnt) begin
          mem_cs  = 1'b1;
          state_d = CAP_B;
        end
      end
      CAP_B: begin
        irb_ld  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (ir_ready) begin
          pc_d    = pc_q + TWO;
          state_d = REQ_A;
        end
      end
      default: state_d = REQ_A;
    endcase

    // A redirect wins over everything, including a same-cycle handshake;
    // read data already in flight is dropped by suppressing the IR loads.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = REQ_A;
      ira_ld  = 1'b0;
      irb_ld  = 1'b0;
    end
  end

  assign mem_oe = mem_cs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ_A;
      pc_q     <= RESET_PC;
      ira      <= '0;
      irb      <= '0;
      ir_valid <= 1'b0;
      pc_next  <= RESET_PC + TWO;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if (ira_ld) ira <= mem_rdata;
      if (irb_ld) irb <= mem_rdata;
      // ir_valid mirrors HOLD but is registered so execute sees a clean flop.
      ir_valid <= (state_d == HOLD);
      pc_next  <= pc_d + TWO;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam logic [7:0] RST_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_gnt = 1'b0;
  logic       ir_ready = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem_addr, ira, irb, pc_next;
  logic       mem_cs, mem_oe, ir_valid;

  instr_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .bus_gnt(bus_gnt),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ira(ira), .irb(irb), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] pn; } exp_t;
  exp_t       q[$];
  logic [7:0] ptr = RST_PC;
  int checks = 0, failures = 0, hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference stream: instructions sit at ptr, ptr+2, ... (mod 256) until a redirect or reset.
  task automatic prime();
    exp_t e;
    logic [7:0] p1, p2;
    while (q.size() < 2) begin
      p1 = ptr + 8'd1;
      p2 = ptr + 8'd2;
      e.a = ram[ptr]; e.b = ram[p1]; e.pn = p2;
      q.push_back(e);
      ptr = p2;
    end
  endtask

  logic       s_valid, s_cs;
  logic [7:0] s_addr, s_ira, s_irb, s_pn;

  task automatic cyc(input logic r, input logic g, input logic y, input logic v, input logic [7:0] p);
    rst = r; bus_gnt = g; ir_ready = y; redirect_valid = v; redirect_pc = p;
    @(negedge clk);
    s_valid = ir_valid; s_cs = mem_cs; s_addr = mem_addr;
    s_ira = ira; s_irb = irb; s_pn = pc_next;
    @(posedge clk); #1;
    if (r || v) begin
      q.delete();
      ptr = r ? RST_PC : p;
    end
    prime();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
  endtask

  // Monitor: every presented instruction must match the scoreboard head.
  logic prev_kill = 1'b0, prev_hold = 1'b0;
  always @(negedge clk) begin
    if (prev_kill) chk("valid_after_kill", ir_valid, 1'b0);
    if (prev_hold) chk("valid_held", ir_valid, 1'b1);
    if (ir_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=valid required=no_instruction");
      end else begin
        chk("ira", ira, q[0].a);
        chk("irb", irb, q[0].b);
        chk("pc_next", pc_next, q[0].pn);
        if (ir_ready) begin
          void'(q.pop_front());
          hs++;
        end
      end
    end
    prev_kill = rst || redirect_valid;
    prev_hold = (ir_valid === 1'b1) && !ir_ready && !rst && !redirect_valid;
  end

  initial begin
    logic [7:0] mask8;
    logic [8:0] mask9;
    int cs_cnt, first;
    logic found;

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h00] = 8'h10; ram[8'h01] = 8'h1C; ram[8'h02] = 8'h30; ram[8'h03] = 8'h1D;
    ram[8'h18] = 8'h90; ram[8'h19] = 8'h00; ram[8'hFF] = 8'h70;

    // Reset values
    do_reset();
    cyc(0, 0, 0, 0, 8'h00);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_ira", s_ira, 8'h00);
    chk("rst_irb", s_irb, 8'h00);
    chk("rst_addr", s_addr, RST_PC);
    chk("rst_cs", s_cs, 1'b0);
    chk("rst_pc_next", s_pn, 8'h02);

    // Full-speed fetch: valid in cycles 3 and 7
    do_reset();
    mask8 = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      mask8[i] = s_valid;
      if (i == 7) begin
        chk("seq2_ira", s_ira, 8'h30);
        chk("seq2_pc_next", s_pn, 8'h04);
      end
    end
    chk("valid_pattern_fullspeed", mask8, 8'h88);

    // Execute stalls in HOLD: instruction stable, no RAM traffic
    do_reset();
    mask9 = '0; cs_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      mask9[i] = s_valid;
      if (i >= 2 && s_cs) cs_cnt++;
    end
    chk("valid_pattern_hold", mask9, 9'h1F8);
    chk("hold_ram_requests", cs_cnt, 0);
    chk("hold_ira", s_ira, 8'h10);
    chk("hold_irb", s_irb, 8'h1C);

    // Grant withheld in cycles 0-2 and 4
    do_reset();
    first = 99;
    for (int i = 0; i < 10; i++) begin
      cyc(0, !(i <= 2 || i == 4), 0, 0, 8'h00);
      if (s_valid && first == 99) first = i;
    end
    chk("stall_first_valid_cycle", first, 7);
    chk("stall_ira", s_ira, 8'h10);

    // Redirect to 18 while capturing A of the second instruction
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 1, i == 5, 8'h18);
      if (i == 6) begin
        chk("redir_ira_kept", s_ira, 8'h10);
        chk("redir_first_addr", s_addr, 8'h18);
        chk("redir_first_cs", s_cs, 1'b1);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      found = s_valid;
    end
    chk("redir_found", found, 1'b1);
    chk("redir_ira", s_ira, 8'h90);
    chk("redir_irb", s_irb, 8'h00);

    // PC wrap at FF
    do_reset();
    cyc(0, 1, 0, 1, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      found = s_valid;
    end
    chk("wrap_found", found, 1'b1);
    chk("wrap_ira", s_ira, 8'h70);
    chk("wrap_irb", s_irb, 8'h10);
    chk("wrap_pc_next", s_pn, 8'h01);

    // Reset landing in CAP_B
    do_reset();
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    chk("rstcapb_valid", s_valid, 1'b0);
    chk("rstcapb_ira", s_ira, 8'h00);
    chk("rstcapb_irb", s_irb, 8'h00);
    chk("rstcapb_pc", s_addr, RST_PC);
    chk("rstcapb_pc_next", s_pn, 8'h02);

    // Random traffic against the scoreboard
    hs = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 200) == 0, ($urandom % 10) < 7, $urandom % 2,
          ($urandom % 40) == 0, 8'($urandom));
    end
    chk("random_handshakes_ge_100", hs >= 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 8-bit accumulator CPU. It reads each 2-byte instruction (opcode/mode byte, then operand byte) from the shared single-port synchronous RAM and holds it in IRA/IRB. It then presents the instruction to the decode/execute stage over a valid/ready handshake. The block owns the program counter, accepts redirects (jump, skip, jump-with-link, return, halt) from execute, and uses the RAM port only when the bus arbiter grants it.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of PC and RAM address
- DATA_WIDTH, 8, RAM word width; IRA and IRB are each one word
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- bus_gnt  in  1  fetch may drive a RAM read this cycle
- mem_addr  out  ADDR_WIDTH  RAM address (MAR source while granted)
- mem_cs  out  1  RAM chip select, read cycles only
- mem_oe  out  1  RAM output enable; fetch never asserts a write enable
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a request
- ir_valid  out  1  IRA/IRB hold a complete instruction
- ir_ready  in  1  execute accepts the instruction
- ira  out  DATA_WIDTH  opcode byte, [7:4] opcode, [1:0] skip condition
- irb  out  DATA_WIDTH  operand/address byte
- pc_next  out  ADDR_WIDTH  address after the held instruction (PC+2), used for skip and link
- redirect_valid  in  1  load a new PC
- redirect_pc  in  ADDR_WIDTH  target PC

## Operation
- FSM states are REQ_A, CAP_A, REQ_B, CAP_B and HOLD. Reset enters REQ_A.
- REQ_A: drive mem_addr=PC. If bus_gnt is high, assert mem_cs=mem_oe=1 and go to CAP_A; otherwise stay.
- CAP_A: IRA <= mem_rdata. Drive mem_addr=PC+1. If bus_gnt is high, assert cs/oe and go to CAP_B; otherwise go to REQ_B.
- REQ_B: same as REQ_A, but with address PC+1 and next state CAP_B.
- CAP_B: IRB <= mem_rdata, then go to HOLD.
- HOLD: ir_valid=1. ira/irb/pc_next stay stable until the handshake.
  - When ir_valid & ir_ready: PC <= PC+2, go to REQ_A.
- mem_cs and mem_oe are 0 in CAP_B, HOLD, and any state with bus_gnt=0.
- Redirect takes priority in every state:
  - PC <= redirect_pc, next state REQ_A.
  - Any in-flight read data is discarded; IRA/IRB are not updated that cycle.
  - ir_valid is 0 from the next cycle.
- Redirect in the same cycle as a handshake: the held instruction counts as consumed and PC takes redirect_pc, not PC+2.
- All address arithmetic is modulo 2^ADDR_WIDTH. At PC=8'hFF, IRB is read from 8'h00 and pc_next is 8'h01. No error is flagged for odd or unaligned PCs.
- Fetch does not decode opcodes. Halt is implemented by execute redirecting to the halt address.

## Timing
- Reset values: PC=RESET_PC, state=REQ_A, ira=irb=0, ir_valid=0, mem_cs=mem_oe=0, mem_addr=RESET_PC, pc_next=RESET_PC+2.
- A reset that lands mid-fetch or in HOLD aborts the fetch. No stale IR is ever presented.
- With bus_gnt held at 1, the cycle sequence is:
  - cycle 0: REQ_A request
  - cycle 1: IRA captured, B request
  - cycle 2: IRB captured
  - cycle 3: ir_valid=1
- Peak throughput is one instruction per 4 cycles. ir_ready=1 in cycle 3 gives the next REQ_A in cycle 4.
- Each cycle with bus_gnt low in a request state adds exactly one cycle of latency.
- mem_addr, mem_cs and mem_oe are combinational from state, PC and bus_gnt. ir_valid, ira, irb and pc_next are registered.
- ir_valid never drops without a handshake, redirect or reset.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t enum
  - opcode constants: LOAD 4'h1, STORE 4'h2, ADD 4'h3, SUB 4'h4, HALT 4'h7, SKIP 4'h8, JUMP 4'h9, CLEAR 4'hA, RETURN 4'hB, JNS 4'hC
  - ADDR_W and DATA_W defaults
- Single module with no sub-modules. The PC incrementers are inline.

## Test plan
- Preload RAM 00:10, 01:1C, 02:30, 03:1D; gnt=1, ready=1 -> instruction (10,1C) valid in cycle 3 with pc_next=02; instruction (30,1D) valid in cycle 7 with pc_next=04.
- ir_ready held 0 for 5 cycles in HOLD -> ira=10, irb=1C and ir_valid=1 stay stable; no RAM requests are issued.
- bus_gnt low in cycles 0-2 and cycle 4 -> ir_valid asserts in cycle 7, and IR contents are unchanged versus the no-stall case.
- redirect_pc=18 asserted in CAP_A -> the first request after redirect is address 18; old IRA is not overwritten; the next instruction is (90,00).
- PC=FF with RAM FF:70, 00:10 -> ira=70, irb=10, pc_next=01.
- rst asserted in CAP_B -> the next cycle has ir_valid=0, ira=irb=0, and PC=RESET_PC.
